// File: rtl/rf_dump_streamer.sv
// rf_dump_streamer: register-file dump engine for the sccomp debug read port.
//
// Counts cycles after reset and waits in IDLE for a halt condition: an explicit
// start pulse, a PC match or the cycle limit. When one fires, it walks the
// register file through reg_sel and streams a fixed word sequence over a
// valid/ready interface: cycle snapshot, PC snapshot, x0..x(NREG-1).
// Exactly one dump is produced per reset.
//
// Optional feature macro: RF_DUMP_CHECKSUM_EN appends one extra word after the
// last register: the XOR of every preceding word in the dump. m_last then marks
// that word instead of the last register.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   start    single-cycle dump request
//   halt_en  enables the PC-match trigger
//   halt_pc  PC value that triggers a dump
//   pc_in    current CPU PC
//   reg_sel  register index driven to the CPU debug port
//   reg_data combinational register read data for reg_sel
//   m_valid  stream word valid
//   m_ready  consumer accepts the word
//   m_data   stream word
//   m_last   final word of the dump
//   busy     dump in progress
//   done     dump complete, sticky until rst

module rf_dump_streamer #(
  parameter int unsigned NREG        = 32,
  parameter int unsigned SEL_W       = 5,
  parameter int unsigned CYCLE_LIMIT = 20000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_en,
  input  logic [31:0]      halt_pc,
  input  logic [31:0]      pc_in,
  output logic [SEL_W-1:0] reg_sel,
  input  logic [31:0]      reg_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [31:0]      m_data,
  output logic             m_last,
  output logic             busy,
  output logic             done
);

  localparam logic [31:0]      CycTrig = 32'(CYCLE_LIMIT - 1);
  localparam logic [SEL_W-1:0] IdxLast = SEL_W'(NREG - 1);

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StSel,
    StSend,
`ifdef RF_DUMP_CHECKSUM_EN
    StCsum,
`endif
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      cyc_q, cyc_d;
  logic [31:0]      pc_snap_q, pc_snap_d;
  logic             hdr_pc_q, hdr_pc_d;  // 0: word0 (cycle) on the bus, 1: word1 (PC)
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             m_valid_q, m_valid_d;
  logic [31:0]      m_data_q, m_data_d;
  logic             m_last_q, m_last_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             hs;
  logic             trigger;
  logic             idx_is_last;

`ifdef RF_DUMP_CHECKSUM_EN
  logic [31:0]      csum_q, csum_d;
`endif

  assign hs          = m_valid_q && m_ready;
  assign trigger     = start || (halt_en && (pc_in == halt_pc)) || (cyc_q == CycTrig);
  assign idx_is_last = (idx_q == IdxLast);

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    pc_snap_d = pc_snap_q;
    hdr_pc_d  = hdr_pc_q;
    idx_d     = idx_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    busy_d    = busy_q;
    done_d    = done_q;

    unique case (state_q)
      StIdle: begin
        if (cyc_q != '1) begin
          cyc_d = cyc_q + 32'd1;
        end
        if (trigger) begin
          // Word0 goes straight onto the bus; the PC waits in pc_snap for word1.
          pc_snap_d = pc_in;
          m_data_d  = cyc_q;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          hdr_pc_d  = 1'b0;
          busy_d    = 1'b1;
          state_d   = StHdr;
        end
      end

      StHdr: begin
        if (hs) begin
          if (!hdr_pc_q) begin
            m_data_d = pc_snap_q;
            hdr_pc_d = 1'b1;
          end else begin
            m_valid_d = 1'b0;
            idx_d     = '0;
            state_d   = StSel;
          end
        end
      end

      StSel: begin
        // x0 is hardwired to zero whatever the debug port returns.
        m_data_d  = (idx_q == '0) ? 32'd0 : reg_data;
        m_valid_d = 1'b1;
`ifdef RF_DUMP_CHECKSUM_EN
        m_last_d  = 1'b0;
`else
        m_last_d  = idx_is_last;
`endif
        state_d   = StSend;
      end

      StSend: begin
        if (hs) begin
          if (idx_is_last) begin
`ifdef RF_DUMP_CHECKSUM_EN
            m_data_d = csum_q ^ m_data_q;
            m_last_d = 1'b1;
            state_d  = StCsum;
`else
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            state_d   = StDone;
`endif
          end else begin
            idx_d     = idx_q + SEL_W'(1);
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = StSel;
          end
        end
      end

`ifdef RF_DUMP_CHECKSUM_EN
      StCsum: begin
        if (hs) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          state_d   = StDone;
        end
      end
`endif

      StDone: begin
        // Terminal until reset: no further dumps.
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

`ifdef RF_DUMP_CHECKSUM_EN
  // Running XOR of every accepted word; cleared while waiting for a trigger.
  always_comb begin
    csum_d = csum_q;
    if (state_q == StIdle) begin
      csum_d = '0;
    end else if (hs) begin
      csum_d = csum_q ^ m_data_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cyc_q     <= '0;
      pc_snap_q <= '0;
      hdr_pc_q  <= 1'b0;
      idx_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      pc_snap_q <= pc_snap_d;
      hdr_pc_q  <= hdr_pc_d;
      idx_q     <= idx_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // reg_sel follows idx, which only moves on entry to SEL, so it holds its
  // last value everywhere else.
  assign reg_sel = idx_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
